// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues one-cycle-latency memory reads and buffers {pc, inst, jump}
// entries for decode. Define FETCH_QUEUE_BYPASS_EN to forward responses straight to an empty queue's outputs.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                bpu_next_pc,
  input  logic                       bpu_jump,
  input  logic                       ex_redirect,
  input  logic [31:0]                ex_redirect_pc,
  input  logic                       dc_redirect,
  input  logic [31:0]                dc_redirect_pc,
  output logic                       im_req,
  output logic [31:0]                im_addr,
  input  logic [31:0]                im_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_inst,
  output logic                       out_jump,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]    pc;
  logic           resp_valid;
  logic [31:0]    resp_addr;
  logic           resp_jump;
  logic [31:0]    q_pc   [DEPTH];
  logic [31:0]    q_inst [DEPTH];
  logic [DEPTH-1:0] q_jump;
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;

  logic           redirect;
  logic [CW:0]    occupancy;
  logic           push;
  logic           bypass;
  logic           q_pop;
  logic           enq;

  assign redirect  = ex_redirect | dc_redirect;
  // The outstanding response counts against capacity so an arriving push can never overflow.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, resp_valid};
  assign push      = resp_valid & ~redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = push & (count == CW'(0));
`else
  assign bypass = 1'b0;
`endif

  assign q_pop = (count != CW'(0)) & out_ready & ~redirect;
  assign enq   = push & ~(bypass & out_ready);

  // Fetch address selection and request generation.
  always_comb begin
    if (ex_redirect) begin
      im_addr = ex_redirect_pc;
    end else if (dc_redirect) begin
      im_addr = dc_redirect_pc;
    end else begin
      im_addr = pc;
    end
    im_req = ~rst & (redirect | (occupancy < (CW+1)'(DEPTH)));
  end

  // Head presentation: queued entry first, bypassed response only when the queue is empty.
  always_comb begin
    out_valid = ~rst & ((count != CW'(0)) | bypass);
    if (rst) begin
      out_pc   = 32'h0;
      out_inst = 32'h0;
      out_jump = 1'b0;
    end else if (count != CW'(0)) begin
      out_pc   = q_pc[rd_ptr];
      out_inst = q_inst[rd_ptr];
      out_jump = q_jump[rd_ptr];
    end else if (bypass) begin
      out_pc   = resp_addr;
      out_inst = im_rdata;
      out_jump = resp_jump;
    end else begin
      out_pc   = 32'h0;
      out_inst = 32'h0;
      out_jump = 1'b0;
    end
  end

  // PC, response tracking, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      resp_valid <= 1'b0;
      resp_addr  <= 32'h0;
      resp_jump  <= 1'b0;
      rd_ptr     <= PW'(0);
      wr_ptr     <= PW'(0);
      count      <= CW'(0);
    end else begin
      resp_valid <= im_req;
      if (im_req) begin
        pc        <= bpu_next_pc;
        resp_addr <= im_addr;
        resp_jump <= bpu_jump;
      end
      if (redirect) begin
        rd_ptr <= PW'(0);
        wr_ptr <= PW'(0);
        count  <= CW'(0);
      end else begin
        if (enq) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (q_pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        case ({enq, q_pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Entry storage; contents are only observed behind count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (enq && !rst) begin
      q_pc[wr_ptr]   <= resp_addr;
      q_inst[wr_ptr] <= im_rdata;
      q_jump[wr_ptr] <= resp_jump;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: random redirects, backpressure and resets against a
// queue-level model of fetched entries; define FETCH_QUEUE_BYPASS_EN to match a bypass build.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          CW       = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   bpu_next_pc;
  logic          bpu_jump;
  logic          ex_redirect;
  logic [31:0]   ex_redirect_pc;
  logic          dc_redirect;
  logic [31:0]   dc_redirect_pc;
  logic          im_req;
  logic [31:0]   im_addr;
  logic [31:0]   im_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_inst;
  logic          out_jump;
  logic [CW-1:0] count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        jump;
  } entry_t;

  entry_t      exp_q[$];
  entry_t      pend;
  logic        pend_v;
  logic [31:0] model_pc;
  logic        m_redir;
  logic        m_req;
  logic        m_arrive;
  logic [31:0] m_addr;
  int          n_cmp = 0;
  int          n_err = 0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .bpu_next_pc(bpu_next_pc), .bpu_jump(bpu_jump),
    .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
    .dc_redirect(dc_redirect), .dc_redirect_pc(dc_redirect_pc),
    .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_jump(out_jump),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] next_pc_f(input logic [31:0] a, input logic j);
    return j ? (a + 32'h40) : (a + 32'h4);
  endfunction

  assign bpu_next_pc = next_pc_f(im_addr, bpu_jump);

  // Instruction memory: data for the accepted address appears one cycle later, junk otherwise.
  always @(posedge clk) begin
    im_rdata <= im_req ? mem_f(im_addr) : $urandom;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model and monitor, evaluated mid-cycle for the edge that follows.
  initial begin
    pend_v   = 1'b0;
    pend     = '0;
    model_pc = RESET_PC;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_im_req", 32'(im_req), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'h0);
        exp_q.delete();
        pend_v   = 1'b0;
        model_pc = RESET_PC;
      end else begin
        m_redir = ex_redirect | dc_redirect;
        m_addr  = ex_redirect ? ex_redirect_pc : (dc_redirect ? dc_redirect_pc : model_pc);
        m_req   = m_redir || ((exp_q.size() + int'(pend_v)) < DEPTH);
        chk("count", 32'(count), 32'(exp_q.size()));
        chk("im_req", 32'(im_req), 32'(m_req));
        if (m_req) chk("im_addr", im_addr, m_addr);
        m_arrive = pend_v & ~m_redir;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (m_arrive && exp_q.size() == 0) begin
          exp_q.push_back(pend);
          m_arrive = 1'b0;
        end
`endif
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          chk("out_pc", out_pc, exp_q[0].pc);
          chk("out_inst", out_inst, exp_q[0].inst);
          chk("out_jump", 32'(out_jump), 32'(exp_q[0].jump));
          if (out_ready && !m_redir) void'(exp_q.pop_front());
        end
        if (m_redir) exp_q.delete();
        else if (m_arrive) exp_q.push_back(pend);
        pend_v = m_req;
        pend   = '{pc: m_addr, inst: mem_f(m_addr), jump: bpu_jump};
        if (m_req) model_pc = next_pc_f(m_addr, bpu_jump);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Stimulus: directed scenarios followed by a randomized run.
  initial begin
    rst = 1'b1; bpu_jump = 1'b0; out_ready = 1'b0;
    ex_redirect = 1'b0; ex_redirect_pc = 32'h0;
    dc_redirect = 1'b0; dc_redirect_pc = 32'h0;
    cyc(3);
    rst = 1'b0; out_ready = 1'b1;
    cyc(20);

    out_ready = 1'b0;
    cyc(10);
    chk("bp_count_full", 32'(count), 32'(DEPTH));
    chk("bp_im_req_low", 32'(im_req), 32'd0);

    ex_redirect = 1'b1; ex_redirect_pc = 32'h100;
    cyc(1);
    ex_redirect = 1'b0; out_ready = 1'b1;
    chk("ex_flush_count", 32'(count), 32'd0);
    cyc(10);

    ex_redirect = 1'b1; ex_redirect_pc = 32'h200;
    dc_redirect = 1'b1; dc_redirect_pc = 32'h300;
    cyc(1);
    ex_redirect = 1'b0; dc_redirect = 1'b0;
    cyc(10);

    for (int i = 0; i < 3 * DEPTH + 20; i++) begin
      out_ready = i[0];
      cyc(1);
    end

    dc_redirect = 1'b1; dc_redirect_pc = 32'h400;
    cyc(1);
    dc_redirect = 1'b0; out_ready = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0; out_ready = 1'b1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_refetch", im_addr, RESET_PC);
    cyc(10);

    for (int i = 0; i < 4000; i++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      bpu_jump       = ($urandom_range(0, 7) == 0);
      ex_redirect    = ($urandom_range(0, 19) == 0);
      ex_redirect_pc = $urandom;
      dc_redirect    = ($urandom_range(0, 19) == 0);
      dc_redirect_pc = $urandom;
      rst            = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    rst = 1'b0; ex_redirect = 1'b0; dc_redirect = 1'b0; out_ready = 1'b1;
    cyc(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-002 SHALL have parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 SHALL have port clk  in  1  clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port bpu_next_pc  in  32  predicted next PC, computed from im_addr.
REQ-006 SHALL have port bpu_jump  in  1  prediction taken for the PC on im_addr.
REQ-007 SHALL have port ex_redirect / ex_redirect_pc  in  1 / 32  execute mispredict and target.
REQ-008 SHALL have port dc_redirect / dc_redirect_pc  in  1 / 32  decode redirect and target.
REQ-009 SHALL have port im_req / im_addr  out  1 / 32  instruction memory read request and address.
REQ-010 SHALL have port im_rdata  in  32  read data, valid exactly one cycle after an accepted im_req.
REQ-011 SHALL have port out_valid / out_ready  out / in  1 / 1  valid-ready handshake toward decode.
REQ-012 SHALL have port out_pc / out_inst / out_jump  out  32 / 32 / 1  head entry contents.
REQ-013 SHALL have port count  out  $clog2(DEPTH+1)  current queued entries.

Function
REQ-014 SHALL drive im_addr = ex_redirect ? ex_redirect_pc : dc_redirect ? dc_redirect_pc : pc.
REQ-015 SHALL assert im_req when any redirect is high, or when count + inflight < DEPTH, with inflight the 1-bit outstanding-response flag.
REQ-016 SHALL load pc <= bpu_next_pc on each cycle im_req is high; pc holds otherwise.
REQ-017 SHALL capture im_addr, bpu_jump and a valid bit into a response register when im_req is high; the next cycle pushes {addr, im_rdata, jump} into the queue.
REQ-018 SHALL, on any redirect, clear all queue entries, clear count and squash the outstanding response, so the only response accepted next cycle is the redirect fetch.
REQ-019 SHALL give ex_redirect priority over dc_redirect when both are high; only ex_redirect_pc is fetched.
REQ-020 SHALL assert out_valid iff count != 0; out_pc/out_inst/out_jump SHALL show the oldest entry.
REQ-021 SHALL pop the head on out_valid && out_ready; simultaneous push and pop SHALL leave count unchanged and keep FIFO order.
REQ-022 SHALL never overflow; a push with count == DEPTH is impossible by REQ-015. Full condition is count == DEPTH.
REQ-023 SHALL wrap read and write pointers modulo DEPTH.
REQ-024 SHALL hold head outputs stable while out_valid && !out_ready.
REQ-025 SHALL ignore out_ready on the cycle a redirect is high; no pop occurs.

Reset
REQ-026 SHALL on rst set pc = RESET_PC, count = 0, pointers = 0, inflight = 0, im_req = 0, out_valid = 0, out_pc = 0, out_inst = 0, out_jump = 0.
REQ-027 SHALL issue the first im_req with im_addr = RESET_PC in the first cycle after rst deasserts.
REQ-028 SHALL have rst asserted mid-operation override redirects and discard all queued and in-flight data.

Configuration
REQ-029 SHALL, with FETCH_QUEUE_BYPASS_EN defined, present an arriving response directly on outputs when count == 0, with out_valid high that cycle; if out_ready is high the entry SHALL NOT be enqueued.
REQ-030 SHALL, without FETCH_QUEUE_BYPASS_EN, always enqueue responses, giving 2-cycle fetch-to-out_valid latency after an empty queue.

Verification
REQ-031 SHALL cover reset start: rst low, out_ready=1, bpu_next_pc=pc+4 -> im_addr 0,4,8; out_pc 0 at cycle 2 (1 with bypass), 4 next cycle.
REQ-032 SHALL cover backpressure: out_ready=0 for 10 cycles, DEPTH=4 -> count saturates at 4, im_req low, out_pc stable at 0.
REQ-033 SHALL cover execute redirect: queue holds 3 entries, ex_redirect_pc=0x100 -> count=0 next cycle, next out_pc=0x100, no stale entry.
REQ-034 SHALL cover simultaneous redirects: ex=0x200, dc=0x300 same cycle -> im_addr=0x200, 0x300 never output.
REQ-035 SHALL cover pointer wrap: 3*DEPTH+1 fetches with alternating out_ready -> out_pc sequence strictly +4, no loss or duplicate.
REQ-036 SHALL cover mid-run reset: rst pulsed with count=2 and inflight=1 -> out_valid=0, refetch from RESET_PC.
